// File: rtl/log2_pkg.sv
// rtl/log2_pkg.sv - constants shared by the log2 core and its scheduler
// Core geometry and the tag layout {valid, idx, zero} carried alongside each issue.
package log2_pkg;

   localparam int LOG2_LAT  = 3;
   localparam int I_WIDTH   = 64;
   localparam int O_WIDTH_F = 8;
   localparam int O_WIDTH   = O_WIDTH_F + $clog2(I_WIDTH);

   localparam int TAG_VALID_W = 1;
   localparam int TAG_ZERO_W  = 1;

   function automatic int idx_width(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   function automatic int tag_width(input int n_req);
      return TAG_VALID_W + idx_width(n_req) + TAG_ZERO_W;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant, search starts one past the last winner
// Purely combinational; the caller owns and updates the pointer.
module rr_arbiter
   import log2_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Walk from the farthest offset down so the nearest requester after ptr wins.
   always_comb begin
      grant    = '0;
      idx      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         cand     = (int'(ptr) + off) % N_REQ;
         cand_idx = IDX_W'(cand);
         if (en && req[cand_idx]) begin
            grant           = '0;
            grant[cand_idx] = 1'b1;
            idx             = cand_idx;
         end
      end
   end

endmodule

// File: rtl/log2_share_sched.sv
// rtl/log2_share_sched.sv - time-shares one pipelined log2 core among N_REQ requesters
// Issues are tagged with their owner so results return in order, one per cycle.
module log2_share_sched
   import log2_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int I_WIDTH   = log2_pkg::I_WIDTH,
   parameter int O_WIDTH_F = log2_pkg::O_WIDTH_F,
   parameter int O_WIDTH   = O_WIDTH_F + $clog2(I_WIDTH),
   parameter int LOG2_LAT  = log2_pkg::LOG2_LAT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*I_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic [I_WIDTH-1:0]       log_i_data,
   input  logic [O_WIDTH-1:0]       log_o_data,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [O_WIDTH-1:0]       rsp_data,
   output logic                     rsp_zero,
   output logic                     busy
);

   localparam int IDX_W = idx_width(N_REQ);
   localparam int TAG_W = tag_width(N_REQ);

   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   gnt_idx;
   logic [N_REQ-1:0]   gnt;
   logic               accept;
   logic [I_WIDTH-1:0] gnt_data;
   logic [TAG_W-1:0]   tag_pipe [LOG2_LAT];

   logic               last_valid;
   logic [IDX_W-1:0]   last_idx;
   logic               last_zero;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (en),
      .grant (gnt),
      .idx   (gnt_idx)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;
   assign gnt_data  = req_data[int'(gnt_idx)*I_WIDTH +: I_WIDTH];

   assign last_valid = tag_pipe[LOG2_LAT-1][TAG_W-1];
   assign last_idx   = tag_pipe[LOG2_LAT-1][TAG_W-2:1];
   assign last_zero  = tag_pipe[LOG2_LAT-1][0];

   // The operand register only loads on a grant so the core input does not toggle when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= IDX_W'(N_REQ - 1);
         log_i_data <= '0;
         rsp_valid  <= '0;
         rsp_zero   <= 1'b0;
         for (int i = 0; i < LOG2_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         if (accept) begin
            ptr        <= gnt_idx;
            log_i_data <= gnt_data;
         end
         tag_pipe[0] <= {accept, gnt_idx, ~|gnt_data};
         for (int i = 1; i < LOG2_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
         rsp_valid <= last_valid ? (N_REQ'(1) << last_idx) : '0;
         rsp_zero  <= last_valid & last_zero;
      end
   end

   assign rsp_data = log_o_data;

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LOG2_LAT; i++) busy = busy | tag_pipe[i][TAG_W-1];
   end

endmodule

// File: tb/tb_log2_share_sched.sv
// tb/tb_log2_share_sched.sv - scoreboard bench with a behavioural 3-cycle log2 core
module tb_log2_share_sched;
   import log2_pkg::*;

   localparam int N  = 4;
   localparam int IW = 64;
   localparam int OW = 14;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*IW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic [IW-1:0]   log_i_data;
   logic [OW-1:0]   log_o_data;
   logic [N-1:0]    rsp_valid;
   logic [OW-1:0]   rsp_data;
   logic            rsp_zero;
   logic            busy;

   always #5 clk = ~clk;

   log2_share_sched #(.N_REQ(N), .I_WIDTH(IW), .O_WIDTH_F(8), .O_WIDTH(OW), .LOG2_LAT(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .log_i_data (log_i_data),
      .log_o_data (log_o_data),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero),
      .busy       (busy)
   );

   function automatic logic [OW-1:0] log2_ref(input logic [IW-1:0] x);
      int p;
      logic [IW-1:0] m;
      p = 0;
      for (int i = 0; i < IW; i++) if (x[i]) p = i;
      if (p >= 8) m = x >> (p - 8);
      else        m = x << (8 - p);
      return {6'(p), m[7:0]};
   endfunction

   logic [OW-1:0] p1, p2, p3;
   always @(posedge clk) begin
      p1 <= log2_ref(log_i_data);
      p2 <= p1;
      p3 <= p2;
   end
   assign log_o_data = p3;

   typedef struct {
      int            idx;
      logic [OW-1:0] data;
      logic          zero;
      int            due;
   } exp_t;

   exp_t          sb[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            acc_cnt[N];
   int            rsp_cnt[N];
   int            mptr = N - 1;
   logic [N-1:0]  vld = '0;
   logic [IW-1:0] dat[N];
   logic          en_r = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [IW-1:0] rand_data();
      logic [IW-1:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 64'd1;
         default: return r >> $urandom_range(0, 63);
      endcase
   endfunction

   // Drive one cycle; expected owner is the first valid requester after the last winner.
   task automatic step();
      logic [N-1:0] exp_g;
      int gi;
      @(negedge clk);
      rst_n = 1'b1;
      en = en_r;
      req_valid = vld;
      for (int i = 0; i < N; i++) req_data[i*IW +: IW] = dat[i];
      #1;
      exp_g = '0;
      gi = -1;
      if (en_r) begin
         for (int off = 1; off <= N; off++) begin
            int c;
            c = (mptr + off) % N;
            if (gi < 0 && vld[c]) gi = c;
         end
      end
      if (gi >= 0) exp_g[gi] = 1'b1;
      checks++;
      if (req_ready !== exp_g) begin
         errors++;
         $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_g);
      end
      checks++;
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0) begin
         errors++;
         $display("FAIL ready_protocol cyc=%0d got=%b valid=%b", cyc, req_ready, req_valid);
      end
      if (gi >= 0) begin
         sb.push_back('{gi, log2_ref(dat[gi]), dat[gi] == '0, cyc + 4});
         acc_cnt[gi]++;
         mptr = gi;
         vld[gi] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      vld = '0;
      while (sb.size() > 0) begin
         acc_cnt[sb[0].idx]--;
         void'(sb.pop_front());
      end
      mptr = N - 1;
   endtask

   task automatic arm(input logic [N-1:0] mask, input bit pow);
      for (int i = 0; i < N; i++) begin
         if (mask[i] && !vld[i]) begin
            vld[i] = 1'b1;
            dat[i] = pow ? (64'd1 << (4 + i)) : rand_data();
         end
      end
   endtask

   always begin
      logic exp_busy;
      @(negedge clk);
      #2;
      exp_busy = 1'b0;
      foreach (sb[i]) if (sb[i].due - 3 <= cyc && cyc < sb[i].due) exp_busy = 1'b1;
      checks++;
      if (busy !== exp_busy) begin
         errors++;
         $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      if (rsp_valid !== '0) begin
         for (int i = 0; i < N; i++) if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;
         checks++;
         if (sb.size() == 0 || sb[0].due != cyc) begin
            errors++;
            $display("FAIL rsp_unexpected cyc=%0d got=%b exp=none", cyc, rsp_valid);
         end else begin
            if (rsp_valid !== (N'(1) << sb[0].idx) || rsp_data !== sb[0].data || rsp_zero !== sb[0].zero) begin
               errors++;
               $display("FAIL rsp cyc=%0d got=%b/%h/%b exp=%b/%h/%b", cyc, rsp_valid, rsp_data, rsp_zero,
                        N'(1) << sb[0].idx, sb[0].data, sb[0].zero);
            end
            void'(sb.pop_front());
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         checks++;
         errors++;
         $display("FAIL rsp_missing cyc=%0d got=%b exp_owner=%0d", cyc, rsp_valid, sb[0].idx);
         void'(sb.pop_front());
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         dat[i] = '0;
         acc_cnt[i] = 0;
         rsp_cnt[i] = 0;
      end
      step();

      vld[2] = 1'b1;
      dat[2] = 64'h400;
      repeat (7) step();

      do_reset();
      for (int k = 0; k < 8; k++) begin
         arm('1, 1'b1);
         step();
      end
      vld = '0;
      repeat (5) step();

      vld[0] = 1'b1; dat[0] = '0;
      step();
      vld[0] = 1'b1; dat[0] = 64'd1;
      repeat (6) step();

      for (int k = 0; k < 2; k++) begin
         arm(4'b1010, 1'b0);
         step();
      end
      en_r = 1'b0;
      for (int k = 0; k < 5; k++) begin
         arm(4'b1010, 1'b0);
         step();
      end
      en_r = 1'b1;
      for (int k = 0; k < 4; k++) begin
         arm(4'b1010, 1'b0);
         step();
      end
      vld = '0;
      repeat (5) step();

      for (int k = 0; k < 3; k++) begin
         arm('1, 1'b0);
         step();
      end
      do_reset();
      for (int k = 0; k < 4; k++) begin
         arm('1, 1'b0);
         step();
      end
      vld = '0;
      repeat (5) step();

      for (int k = 0; k < 10000; k++) begin
         en_r = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < N; i++) begin
            if (!vld[i] && $urandom_range(0, 2) != 0) begin
               vld[i] = 1'b1;
               dat[i] = rand_data();
            end
         end
         if ($urandom_range(0, 999) == 0) do_reset();
         else step();
      end
      en_r = 1'b1;
      vld = '0;
      repeat (8) step();

      for (int i = 0; i < N; i++) begin
         checks++;
         if (rsp_cnt[i] != acc_cnt[i]) begin
            errors++;
            $display("FAIL count_req%0d got=%0d exp=%0d", i, rsp_cnt[i], acc_cnt[i]);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got=%0d exp=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
